forwarding_unit_ctrl: RTL and testbench
=======================================

Name: forwarding_unit_ctrl

Overview:
- Clocked data-hazard detector for the in-order RISC-V integer pipeline.
- Each cycle it takes the destination register of the instruction entering EX, plus that instruction's two source registers.
- It keeps a 3-deep history of earlier destination registers.
- It outputs registered 2-bit mux selects telling the EX operand muxes where each source operand comes from.

Parameters:
- REG_ADDR_W, 5, width of register indices (32 architectural registers).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset; only sampled on the rising edge of clk.
- rd  input  REG_ADDR_W  destination register of the instruction sampled this cycle; 0 means "no write".
- rs1  input  REG_ADDR_W  source register 1 of the same instruction.
- rs2  input  REG_ADDR_W  source register 2 of the same instruction.
- rs1_src  output  2  operand-1 select, registered.
- rs2_src  output  2  operand-2 select, registered.

Behaviour:
- Select encoding:
  - 2'b00 = register file.
  - 2'b01 = EX/MEM result (instruction 1 back).
  - 2'b10 = MEM/WB result (2 back).
  - 2'b11 = write-back bypass (3 back).
- State: history registers h1, h2, h3 (REG_ADDR_W each). h1 holds rd sampled at the previous edge; h2 holds rd from 2 edges ago; h3 holds rd from 3 edges ago.
- Reset (rst=1 at a rising edge):
  - h1, h2, h3 <= 0.
  - rs1_src, rs2_src <= 2'b00.
  - All inputs sampled that edge are discarded; rd is not pushed into history.
- Normal edge (rst=0), all updates simultaneous, compares use pre-edge history values:
  - rsX_src <= sel(rsX), where sel(r) is:
    - 00 if r==0;
    - else 01 if r==h1;
    - else 10 if r==h2;
    - else 11 if r==h3;
    - else 00.
  - Then h1 <= rd, h2 <= h1, h3 <= h2.
- Priority: the most recent producer always wins. If h1==h2==r, the result is 01.
- x0 rule:
  - A source of 0 never forwards.
  - A history entry of 0 never matches a nonzero source; this is implied by the r==0 check.
- The current cycle's rd is never compared with the same cycle's rs1/rs2, so an instruction never forwards to itself.
- rs1 and rs2 are evaluated independently. Both may select the same stage, e.g. rs1==rs2==h1 gives 01/01.
- Latency: outputs reflect the inputs sampled at the most recent rising edge and are stable for the whole following cycle. There is no combinational input-to-output path.
- No stall or flush input. Every non-reset edge shifts the history. Bubbles are represented by driving rd=0.
- Outputs never go X after the first reset. Before the first reset, state is undefined; benches must reset first.
- Width handling: pure equality compares; no arithmetic.

Test Plan:
1. Reset then basic sequence. Sequence: rst=1 for one edge; then edges with (rd,rs1,rs2):
   - (0,1,2) -> 00/00.
   - (1,0,2) -> 00/00.
   - (1,0,1) -> rs1 00 (x0), rs2 01.
   - (3,1,2) -> rs1 01, rs2 00.
2. Stage-2 and stage-3 forwarding:
   - Edges rd=5 (rs=0,0), rd=0, then (rd=0, rs1=5, rs2=0) -> rs1_src=10.
   - Restart from reset: rd=5, rd=0, rd=0, then rs2=5 -> rs2_src=11.
   - One more idle edge past that -> 00 (out of window).
3. Priority:
   - Edges rd=7, rd=7, then rs1=7 -> 01 (h1 beats h2).
   - Edges rd=7, rd=9, then rs1=7, rs2=9 -> 10/01.
4. x0 never forwards: rd=0 on every edge with rs1=rs2=0 -> always 00/00. Confirm h* of 0 produce no match.
5. Synchronous reset mid-stream:
   - Fill history with rd=4,4,4.
   - Assert rst on one edge while presenting rs1=4 -> outputs 00/00.
   - Next edge (rst=0) with rs1=4 -> 00, since history was cleared and the reset-edge rd was discarded.
   - Verify rst pulsed between edges has no effect.
6. Dual match: after rd=12, present rs1=rs2=12 -> 01/01. Outputs hold those values until the next edge.

Source files
------------

// File: rtl/forwarding_unit_ctrl_if.sv
// Operand-forwarding interface: the pipeline presents one instruction's
// destination and source register indices and gets back the EX mux selects.
interface forwarding_unit_ctrl_if #(
  parameter int REG_ADDR_W = 5
);
  logic [REG_ADDR_W-1:0] rd;
  logic [REG_ADDR_W-1:0] rs1;
  logic [REG_ADDR_W-1:0] rs2;
  logic [1:0]            rs1_src;
  logic [1:0]            rs2_src;

  // Pipeline side: drives register indices, consumes selects.
  modport master (
    output rd,
    output rs1,
    output rs2,
    input  rs1_src,
    input  rs2_src
  );

  // Forwarding unit side: consumes register indices, drives selects.
  modport slave (
    input  rd,
    input  rs1,
    input  rs2,
    output rs1_src,
    output rs2_src
  );
endinterface

// File: rtl/forwarding_unit_ctrl.sv
// Clocked data-hazard detector. Keeps the destination registers of the last
// three instructions and produces registered EX operand mux selects:
//   00 register file, 01 one back, 10 two back, 11 three back.
// The most recent producer wins; x0 never forwards; the current rd is never
// compared against the current sources.
module forwarding_unit_ctrl #(
  parameter int REG_ADDR_W = 5
) (
  input logic                  clk,
  input logic                  rst,
  forwarding_unit_ctrl_if.slave bus
);

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = {REG_ADDR_W{1'b0}};

  // History of earlier destination registers (h1 newest).
  logic [REG_ADDR_W-1:0] h1;
  logic [REG_ADDR_W-1:0] h2;
  logic [REG_ADDR_W-1:0] h3;

  logic [1:0] rs1_sel;
  logic [1:0] rs2_sel;
  logic [1:0] rs1_src_reg;
  logic [1:0] rs2_src_reg;

  // Priority select for one source: nearest matching producer wins, x0 never
  // forwards (which also keeps a zero history entry from ever matching).
  function automatic logic [1:0] sel(
    input logic [REG_ADDR_W-1:0] r,
    input logic [REG_ADDR_W-1:0] a,
    input logic [REG_ADDR_W-1:0] b,
    input logic [REG_ADDR_W-1:0] c
  );
    logic [1:0] s;
    if (r == REG_ZERO) begin
      s = 2'b00;
    end else if (r == a) begin
      s = 2'b01;
    end else if (r == b) begin
      s = 2'b10;
    end else if (r == c) begin
      s = 2'b11;
    end else begin
      s = 2'b00;
    end
    return s;
  endfunction

  // Next-cycle selects, computed from the pre-edge history.
  always_comb begin
    rs1_sel = 2'b00;
    rs2_sel = 2'b00;
    rs1_sel = sel(bus.rs1, h1, h2, h3);
    rs2_sel = sel(bus.rs2, h1, h2, h3);
  end

  // Register the selects and shift rd into history; reset discards the sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      h1          <= REG_ZERO;
      h2          <= REG_ZERO;
      h3          <= REG_ZERO;
      rs1_src_reg <= 2'b00;
      rs2_src_reg <= 2'b00;
    end else begin
      h1          <= bus.rd;
      h2          <= h1;
      h3          <= h2;
      rs1_src_reg <= rs1_sel;
      rs2_src_reg <= rs2_sel;
    end
  end

  assign bus.rs1_src = rs1_src_reg;
  assign bus.rs2_src = rs2_src_reg;

endmodule

// File: tb/tb_forwarding_unit_ctrl.sv
// Scoreboard bench for forwarding_unit_ctrl: directed sequences followed by
// random traffic, checked against a list-based model of recent producers.
module tb_forwarding_unit_ctrl;

  localparam int W = 5;

  logic clk;
  logic rst;

  forwarding_unit_ctrl_if #(.REG_ADDR_W(W)) bus ();

  forwarding_unit_ctrl #(.REG_ADDR_W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] e1;
    logic [1:0] e2;
    int         id;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   step_id = 0;

  // Model: list of the most recent destination registers, newest first.
  int recent[$];

  function automatic logic [1:0] model_sel(input int r);
    if (r == 0) return 2'b00;
    for (int k = 0; k < recent.size(); k++) begin
      if (recent[k] == r) return 2'(k + 1);
    end
    return 2'b00;
  endfunction

  function automatic void model_push(input bit r, input int rd_v,
                                     input int rs1_v, input int rs2_v);
    exp_t e;
    e.id = step_id;
    if (r) begin
      e.e1 = 2'b00;
      e.e2 = 2'b00;
      recent.delete();
    end else begin
      e.e1 = model_sel(rs1_v);
      e.e2 = model_sel(rs2_v);
      recent.push_front(rd_v);
      if (recent.size() > 3) void'(recent.pop_back());
    end
    exp_q.push_back(e);
  endfunction

  // Drive one edge worth of inputs (at negedge) and record its expectation.
  task automatic step(input bit r, input int rd_v, input int rs1_v, input int rs2_v);
    @(negedge clk);
    step_id++;
    rst     = r;
    bus.rd  = W'(rd_v);
    bus.rs1 = W'(rs1_v);
    bus.rs2 = W'(rs2_v);
    model_push(r, rd_v, rs1_v, rs2_v);
  endtask

  // Like step, but pulses rst high and low again between the edges.
  task automatic step_glitch(input int rd_v, input int rs1_v, input int rs2_v);
    step(1'b0, rd_v, rs1_v, rs2_v);
    #2 rst = 1'b1;
    #2 rst = 1'b0;
  endtask

  // Monitor: after each edge pop the expectation, compare, recheck before next drive.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        #1;
        checks++;
        if (bus.rs1_src !== e.e1 || bus.rs2_src !== e.e2) begin
          errors++;
          $display("FAIL sel step%0d: got %b/%b expected %b/%b",
                   e.id, bus.rs1_src, bus.rs2_src, e.e1, e.e2);
        end
        #3;
        checks++;
        if (bus.rs1_src !== e.e1 || bus.rs2_src !== e.e2) begin
          errors++;
          $display("FAIL hold step%0d: got %b/%b expected %b/%b",
                   e.id, bus.rs1_src, bus.rs2_src, e.e1, e.e2);
        end
      end
    end
  end

  // Watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

  // Stimulus.
  initial begin
    rst = 1'b1;
    bus.rd = '0;
    bus.rs1 = '0;
    bus.rs2 = '0;

    // 1. reset then basic sequence
    step(1'b1, 0, 0, 0);
    step(1'b0, 0, 1, 2);
    step(1'b0, 1, 0, 2);
    step(1'b0, 1, 0, 1);
    step(1'b0, 3, 1, 2);

    // 2. two-back and three-back forwarding, then out of window
    step(1'b1, 0, 0, 0);
    step(1'b0, 5, 0, 0);
    step(1'b0, 0, 0, 0);
    step(1'b0, 0, 5, 0);
    step(1'b1, 0, 0, 0);
    step(1'b0, 5, 0, 0);
    step(1'b0, 0, 0, 0);
    step(1'b0, 0, 0, 0);
    step(1'b0, 0, 0, 5);
    step(1'b0, 0, 0, 5);

    // 3. priority
    step(1'b0, 7, 0, 0);
    step(1'b0, 7, 0, 0);
    step(1'b0, 0, 7, 0);
    step(1'b0, 7, 0, 0);
    step(1'b0, 9, 0, 0);
    step(1'b0, 0, 7, 9);

    // 4. x0 never forwards
    for (int i = 0; i < 5; i++) step(1'b0, 0, 0, 0);
    step(1'b0, 0, 31, 1);

    // 5. synchronous reset mid-stream, and a between-edge rst pulse
    step(1'b0, 4, 0, 0);
    step(1'b0, 4, 0, 0);
    step(1'b0, 4, 0, 0);
    step(1'b1, 4, 4, 4);
    step(1'b0, 0, 4, 0);
    step(1'b0, 6, 0, 0);
    step_glitch(0, 6, 0);
    step(1'b0, 0, 6, 6);

    // 6. dual match and hold
    step(1'b0, 12, 0, 0);
    step(1'b0, 0, 12, 12);

    // Random traffic over a small register range to provoke matches.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) < 4) begin
        step(1'b1, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
             int'($urandom_range(0, 7)));
      end else if ($urandom_range(0, 99) < 5) begin
        step_glitch(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                    int'($urandom_range(0, 7)));
      end else begin
        step(1'b0, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
             int'($urandom_range(0, 7)));
      end
    end

    step(1'b0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #6;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
